fc_layer_seq: RTL and testbench
===============================

# fc_layer_seq

Sequential fully-connected layer that consumes the 2×5×5 pooled feature map produced by the 2×2 max-pooling stage and computes NOUT signed fixed-point neuron outputs. It uses one multiply-accumulate per cycle, fetches weights and biases from an external synchronous ROM, and exposes valid/ready handshakes on both sides. It is the classifier stage directly downstream of pooling in the LeNet-style datapath.

## Interface
Parameters:
- bitwidth, 16, width of activations, weights, biases and outputs (signed Q(bitwidth-FRAC).FRAC)
- NOUT, 10, number of output neurons
- FRAC, 8, fractional bits of all fixed-point values
- ACCW, 40, accumulator width; must be ≥ 2·bitwidth+6

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  pooled map valid
- in_ready  output  1  block can accept a pooled map
- featuremap_maxpooled  input  signed [bitwidth-1:0] [1:0][4:0][4:0]  pooled map, sampled only on the accept cycle
- w_rd  output  1  ROM read strobe
- w_addr  output  $clog2(51·NOUT)  ROM word address
- w_data  input  signed bitwidth  ROM read data, valid one cycle after w_rd
- out_valid  output  1  fc_out valid
- out_ready  input  1  downstream accepts fc_out
- fc_out  output  signed [bitwidth-1:0] [NOUT-1:0]  neuron results

## Operation
- Flattened input index k = c·25 + i·5 + j for featuremap_maxpooled[c][i][j], k = 0..49.
- ROM map: weight(n,k) at address n·50+k. Bias(n) at address 50·NOUT+n.
- States: IDLE → MAC → BIAS → DRAIN → (next neuron MAC, or DONE) → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all 50 inputs, clear n and k, go to MAC.
- MAC:
  - Per cycle, w_rd=1 and w_addr=n·50+k; k increments.
  - After k=49 is issued, go to BIAS.
- BIAS: w_rd=1, w_addr=50·NOUT+n; go to DRAIN.
- Accumulation: one cycle after each weight read, acc += x[k]·w_data (full-precision signed product, sign-extended to ACCW). The first product of a neuron overwrites acc instead of adding.
- DRAIN:
  - acc += w_data <<< FRAC (bias read data).
  - Result = acc >>> FRAC (arithmetic shift, floor), saturated to [-2^(bitwidth-1), 2^(bitwidth-1)-1].
  - Result is written to fc_out[n].
  - If n=NOUT-1 go to DONE, else n++, k=0, go to MAC.
- DONE:
  - out_valid=1; fc_out is held stable.
  - On out_ready, go to IDLE. That same cycle out_valid is still 1 and in_ready is 0.
- in_ready is 0 in every state except IDLE. A new map is never accepted while results are pending.
- w_rd is 0 in IDLE, DRAIN and DONE. w_addr is don't-care when w_rd=0 but is driven 0.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after reset release; out_valid=0; w_rd=0; w_addr=0; fc_out all 0; state=IDLE.
- Per neuron: 50 MAC cycles + 1 BIAS cycle + 1 DRAIN cycle = 52 cycles.
- Cycle count: accept at cycle 0 → MAC starts at cycle 1 → out_valid rises at cycle 52·NOUT+1 (521 for NOUT=10).
- ROM latency is fixed at one cycle; the block has no ROM-side stall.
- fc_out[n] may update during computation. It is guaranteed valid only while out_valid=1.
- Reset asserted mid-operation aborts the computation at the next clk edge: all outputs return to their reset values and no partial result is presented.
- in_valid high with out_ready high in IDLE: only the input handshake is relevant.
- out_ready ignored outside DONE.

## Configuration
- FC_RELU_EN defined:
  - Applies ReLU after saturation; any negative result is written as 0.
  - Latency unchanged.
- FC_RELU_EN undefined: saturated signed results are output unchanged, negatives included.

## Test plan
- Reset, then all inputs 256 (1.0), all weights 256, biases 0 → every fc_out = 12800 (50.0); out_valid rises exactly 521 cycles after accept (NOUT=10).
- Input x[k]=k·256, weight(n,k)=(n==k)?256:0, bias(n)=-256 → fc_out[n]=(n-1)·256, so fc_out[0]=-256 without FC_RELU_EN and 0 with FC_RELU_EN.
- All inputs 32512, all weights 32512 → every output saturates to 32767. Same with negated weights → -32768 (0 with FC_RELU_EN).
- Check the w_addr sequence for NOUT=2: 0..49, 100, 50..99, 101, with w_rd low during each DRAIN cycle.
- Hold out_ready=0 for 20 cycles after DONE → out_valid and fc_out stay stable and in_ready=0 even with in_valid=1. Pulse out_ready → next cycle in_ready=1.
- Assert rst_n=0 for one cycle at neuron 3, k=20 → next cycle in IDLE with all outputs 0. A fresh map then produces correct results.

Source files
------------

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected classifier layer.
// Consumes a 2x5x5 pooled map and produces NOUT signed fixed-point neurons.
// The layer uses one multiply-accumulate per cycle.
// Weights and biases come from an external synchronous ROM with a read latency of one cycle.
// Optional feature macro: FC_RELU_EN clamps negative results to zero.
// Without the macro, saturated results are presented as-is.
module fc_layer_seq #(
    parameter int bitwidth = 16,
    parameter int NOUT     = 10,
    parameter int FRAC     = 8,
    parameter int ACCW     = 40
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic signed [1:0][4:0][4:0][bitwidth-1:0] featuremap_maxpooled,
    output logic                                     w_rd,
    output logic [$clog2(51*NOUT)-1:0]               w_addr,
    input  logic signed [bitwidth-1:0]               w_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic signed [NOUT-1:0][bitwidth-1:0]     fc_out
);

    localparam int AW = $clog2(51*NOUT);
    localparam int NW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [NW-1:0] N_LAST    = NW'(NOUT-1);
    localparam logic [AW-1:0] BIAS_BASE = AW'(32'd50 * NOUT);
    localparam logic [AW-1:0] ROW_LEN   = AW'(32'd50);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_BIAS  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_nxt_state;
    logic [NW-1:0]              r_n;
    logic [NW-1:0]              w_nxt_n;
    logic [5:0]                 r_k;
    logic [5:0]                 w_nxt_k;

    logic                       r_in_ready;
    logic                       r_out_valid;
    logic                       r_w_rd;
    logic [AW-1:0]              r_w_addr;
    logic                       w_nxt_in_ready;
    logic                       w_nxt_out_valid;
    logic                       w_nxt_w_rd;
    logic [AW-1:0]              w_nxt_w_addr;

    logic signed [bitwidth-1:0] r_x [0:49];
    logic                       r_dat_wt;   // w_data currently holds a weight
    logic [5:0]                 r_dat_k;    // input index belonging to that weight
    logic signed [ACCW-1:0]     r_acc;
    logic signed [NOUT-1:0][bitwidth-1:0] r_fc;

    logic signed [bitwidth-1:0]   w_x_sel;
    logic signed [2*bitwidth-1:0] w_prod;
    logic signed [ACCW-1:0]       w_prod_ext;
    logic signed [ACCW-1:0]       w_bias_ext;
    logic signed [ACCW-1:0]       w_sum;
    logic signed [ACCW-1:0]       w_shr;
    logic signed [bitwidth-1:0]   w_clip;
    logic signed [bitwidth-1:0]   w_res;

    logic                         w_accept;

    assign w_accept  = in_valid && r_in_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign w_rd      = r_w_rd;
    assign w_addr    = r_w_addr;
    assign fc_out    = r_fc;

    // State and neuron/input counters register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_k     <= 6'd0;
        end else begin
            r_state <= w_nxt_state;
            r_n     <= w_nxt_n;
            r_k     <= w_nxt_k;
        end
    end

    // Next-state and counter sequencing: 50 weight reads, one bias read, one drain per neuron
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_n     = r_n;
        w_nxt_k     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = S_MAC;
                    w_nxt_n     = '0;
                    w_nxt_k     = 6'd0;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_MAC: begin
                if (r_k == 6'd49) begin
                    w_nxt_state = S_BIAS;
                end else begin
                    w_nxt_k = r_k + 6'd1;
                end
            end
            S_BIAS: begin
                w_nxt_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_n == N_LAST) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_MAC;
                    w_nxt_n     = r_n + {{(NW-1){1'b0}}, 1'b1};
                    w_nxt_k     = 6'd0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_state = S_DONE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every port comes straight from a flop
    always_comb begin
        w_nxt_in_ready  = (w_nxt_state == S_IDLE);
        w_nxt_out_valid = (w_nxt_state == S_DONE);
        w_nxt_w_rd      = 1'b0;
        w_nxt_w_addr    = '0;
        case (w_nxt_state)
            S_MAC: begin
                w_nxt_w_rd   = 1'b1;
                w_nxt_w_addr = AW'(w_nxt_n) * ROW_LEN + AW'(w_nxt_k);
            end
            S_BIAS: begin
                w_nxt_w_rd   = 1'b1;
                w_nxt_w_addr = BIAS_BASE + AW'(w_nxt_n);
            end
            default: begin
                w_nxt_w_rd   = 1'b0;
                w_nxt_w_addr = '0;
            end
        endcase
    end

    // Output port registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_rd      <= 1'b0;
            r_w_addr    <= '0;
        end else begin
            r_in_ready  <= w_nxt_in_ready;
            r_out_valid <= w_nxt_out_valid;
            r_w_rd      <= w_nxt_w_rd;
            r_w_addr    <= w_nxt_w_addr;
        end
    end

    assign w_x_sel    = r_x[r_dat_k];
    assign w_prod     = w_x_sel * w_data;
    assign w_prod_ext = {{(ACCW-2*bitwidth){w_prod[2*bitwidth-1]}}, w_prod};
    assign w_bias_ext = {{(ACCW-bitwidth-FRAC){w_data[bitwidth-1]}}, w_data, {FRAC{1'b0}}};
    assign w_sum      = r_acc + w_bias_ext;
    assign w_shr      = w_sum >>> FRAC;

    // Rescale, saturate and optionally rectify the drained neuron value
    always_comb begin
        w_clip = w_shr[bitwidth-1:0];
        if (w_shr > SAT_MAX) begin
            w_clip = SAT_MAX[bitwidth-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_clip = SAT_MIN[bitwidth-1:0];
        end else begin
            w_clip = w_shr[bitwidth-1:0];
        end
`ifdef FC_RELU_EN
        if (w_clip[bitwidth-1]) begin
            w_res = '0;
        end else begin
            w_res = w_clip;
        end
`else
        w_res = w_clip;
`endif
    end

    // Datapath: input latch, ROM-latency tracking, accumulator and result bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 50; k++) begin
                r_x[k] <= '0;
            end
            r_dat_wt <= 1'b0;
            r_dat_k  <= 6'd0;
            r_acc    <= '0;
            r_fc     <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                for (int c = 0; c < 2; c++) begin
                    for (int i = 0; i < 5; i++) begin
                        for (int j = 0; j < 5; j++) begin
                            r_x[c*25 + i*5 + j] <= featuremap_maxpooled[c][i][j];
                        end
                    end
                end
            end
            r_dat_wt <= (r_state == S_MAC);
            r_dat_k  <= r_k;
            if (r_dat_wt) begin
                if (r_dat_k == 6'd0) begin
                    r_acc <= w_prod_ext;
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end
            if (r_state == S_DRAIN) begin
                r_fc[r_n] <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq (NOUT=10) with a behavioural one-cycle ROM.
// Expected neuron values are pushed to a scoreboard queue when a map is sent.
// They are popped and compared when out_valid is seen.
module tb_fc_layer_seq;

    localparam int BW   = 16;
    localparam int NOUT = 10;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                            rst_n;
    logic                            in_valid;
    logic                            in_ready;
    logic [1:0][4:0][4:0][BW-1:0]    fm;
    logic                            w_rd;
    logic [8:0]                      w_addr;
    logic signed [BW-1:0]            w_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NOUT-1:0][BW-1:0]         fc_out;

    int     rom [0:511];
    int     xk  [0:49];
    longint sb_q [$];
    int     n_tot = 0;
    int     n_bad = 0;

    fc_layer_seq #(.bitwidth(BW), .NOUT(NOUT), .FRAC(FRAC), .ACCW(40)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .featuremap_maxpooled (fm),
        .w_rd                 (w_rd),
        .w_addr               (w_addr),
        .w_data               (w_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .fc_out               (fc_out)
    );

    // Synchronous ROM, data one cycle after the read strobe
    always @(posedge clk) begin
        if (w_rd) w_data <= 16'(rom[w_addr]);
    end

    task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint model(input int n);
        longint acc = 0;
        longint r;
        for (int k = 0; k < 50; k++) acc += longint'(xk[k]) * longint'(rom[n*50 + k]);
        acc += longint'(rom[500 + n]) * 256;
        r = acc >>> FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 (first MAC cycle)
    task automatic send_map(input bit do_push);
        int t = 0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    fm[c][i][j] = 16'(xk[c*25 + i*5 + j]);
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("accept", in_ready, 1);
        if (do_push) for (int n = 0; n < NOUT; n++) sb_q.push_back(model(n));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int hold);
        int cyc = 1;
        int errs = 0;
        int p, n, exp_a;
        logic exp_rd;
        logic [NOUT-1:0][BW-1:0] snap;
        while (!out_valid && cyc < 800) begin
            if (cyc <= 520) begin
                p = (cyc - 1) % 52;
                n = (cyc - 1) / 52;
                exp_rd = (p < 51);
                exp_a  = (p < 50) ? n*50 + p : ((p == 50) ? 500 + n : 0);
                if (w_rd !== exp_rd || int'(w_addr) != exp_a) errs++;
            end
            @(negedge clk);
            cyc++;
        end
        check_val("latency", cyc, 521);
        check_val("w_seq_errs", errs, 0);
        for (int k = 0; k < NOUT; k++) begin
            if (sb_q.size() > 0) check_val($sformatf("fc_out%0d", k), $signed(fc_out[k]), sb_q.pop_front());
            else check_val("sb_empty", 1, 0);
        end
        snap = fc_out;
        in_valid = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_inready", in_ready, 0);
            check_val("hold_data", (fc_out === snap), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("done_valid", out_valid, 1);
        check_val("done_inready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("idle_inready", in_ready, 1);
        check_val("idle_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fm = '0;
        for (int a = 0; a < 512; a++) rom[a] = 0;
        repeat (3) @(negedge clk);
        check_val("rst_inready", in_ready, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_wrd", w_rd, 0);
        check_val("rst_waddr", w_addr, 0);
        check_val("rst_fc", (fc_out == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_inready", in_ready, 1);

        // All ones: every neuron is 50.0
        for (int k = 0; k < 50; k++) xk[k] = 256;
        for (int a = 0; a < 510; a++) rom[a] = (a < 500) ? 256 : 0;
        send_map(1'b1);
        wait_result(20);

        // Identity-like weights with bias -1.0
        for (int k = 0; k < 50; k++) xk[k] = k * 256;
        for (int a = 0; a < 500; a++) rom[a] = ((a / 50) == (a % 50)) ? 256 : 0;
        for (int a = 500; a < 510; a++) rom[a] = -256;
        send_map(1'b1);
        wait_result(0);

        // Positive then negative saturation
        for (int k = 0; k < 50; k++) xk[k] = 32512;
        for (int a = 0; a < 510; a++) rom[a] = (a < 500) ? 32512 : 0;
        send_map(1'b1);
        wait_result(0);
        for (int a = 0; a < 500; a++) rom[a] = -32512;
        send_map(1'b1);
        wait_result(0);

        // Random mixed-sign data
        for (int k = 0; k < 50; k++) xk[k] = int'($urandom_range(4095)) - 2048;
        for (int a = 0; a < 510; a++) rom[a] = int'($urandom_range(4095)) - 2048;
        send_map(1'b1);
        wait_result(0);

        // Abort at neuron 3, k=20, then a fresh map
        send_map(1'b0);
        repeat (176) @(negedge clk);
        check_val("abort_addr", w_addr, 170);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_inready", in_ready, 0);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_wrd", w_rd, 0);
        check_val("abort_waddr", w_addr, 0);
        check_val("abort_fc", (fc_out == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_idle", in_ready, 1);
        for (int k = 0; k < 50; k++) xk[k] = int'($urandom_range(8191)) - 4096;
        for (int a = 0; a < 510; a++) rom[a] = int'($urandom_range(8191)) - 4096;
        send_map(1'b1);
        wait_result(0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
